xdma_axi_to_reqrsp_write: RTL and testbench

// - AXI4 write-only slave to reqrsp bridge for XDMA data/cfg ingress.
// - Converts AW/W bursts into one reqrsp write per beat and returns a correct B response after each burst's last beat.
// - Supports up to MaxOutstanding completed-but-unacknowledged bursts, INCR and FIXED bursts, and error drain for unsupported requests.
// - AR/R channels are tied off.

---
 rtl/xdma_axi_to_reqrsp_write.sv | 359 +++++++++++++++++++++++++++++++++++
 tb/tb_xdma_axi_to_reqrsp_write.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_axi_to_reqrsp_write.sv
// ---------------------------------------------------------------------------
// xdma_axi_to_reqrsp_write
//
// AXI4 write-only slave to reqrsp bridge for XDMA data/cfg ingress. Each
// AW/W burst becomes one reqrsp write per beat. A B response is queued once
// the burst's last beat is accepted. Up to MaxOutstanding completed bursts may
// wait for their B handshake. INCR and FIXED bursts are supported. WRAP
// bursts, atomics and oversize beats are drained and answered with SLVERR.
// The AR and R channels are tied off.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous reset, active low
//   busy_o        burst in flight, B pending, or AW/W valid at input
//   axi_req_i     AXI slave request (aw, w and b_ready are used)
//   axi_rsp_o     AXI slave response
//   reqrsp_req_o  reqrsp request (q channel, p_ready)
//   reqrsp_rsp_i  reqrsp response (q_ready is used; the p channel is sunk)
//   beat_cnt_o    accepted write beats  (XDMA_AXI_WRITE_PERF_EN only)
//   burst_cnt_o   B responses issued    (XDMA_AXI_WRITE_PERF_EN only)
//
// Optional feature macro: XDMA_AXI_WRITE_PERF_EN adds the two 32-bit
// performance counters. Without the macro, those ports do not exist.
// ---------------------------------------------------------------------------

package xdma_axi_to_reqrsp_write_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;
  typedef logic [3:0]  id_t;
  typedef logic [0:0]  user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

  typedef enum logic [3:0] {
    AMONone = 4'h0, AMOSwap = 4'h1, AMOAdd = 4'h2, AMOAnd = 4'h3,
    AMOOr   = 4'h4, AMOXor  = 4'h5, AMOMax = 4'h6, AMOMaxu = 4'h7,
    AMOMin  = 4'h8, AMOMinu = 4'h9, AMOLR  = 4'hA, AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    addr_t      addr;
    logic       write;
    amo_op_e    amo;
    data_t      data;
    strb_t      strb;
    logic [2:0] size;
  } reqrsp_q_t;

  typedef struct packed {
    data_t data;
    logic  error;
  } reqrsp_p_t;

  typedef struct packed {
    reqrsp_q_t q;
    logic      q_valid;
    logic      p_ready;
  } reqrsp_req_t;

  typedef struct packed {
    reqrsp_p_t p;
    logic      p_valid;
    logic      q_ready;
  } reqrsp_rsp_t;

endpackage

module xdma_axi_to_reqrsp_write #(
  parameter type axi_in_req_t  = xdma_axi_to_reqrsp_write_pkg::axi_req_t,
  parameter type axi_in_resp_t = xdma_axi_to_reqrsp_write_pkg::axi_resp_t,
  parameter type data_t        = xdma_axi_to_reqrsp_write_pkg::data_t,
  parameter type addr_t        = xdma_axi_to_reqrsp_write_pkg::addr_t,
  parameter type axi_id_t      = xdma_axi_to_reqrsp_write_pkg::id_t,
  parameter type strb_t        = xdma_axi_to_reqrsp_write_pkg::strb_t,
  parameter type reqrsp_req_t  = xdma_axi_to_reqrsp_write_pkg::reqrsp_req_t,
  parameter type reqrsp_rsp_t  = xdma_axi_to_reqrsp_write_pkg::reqrsp_rsp_t,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned DataBytes      = $bits(data_t) / 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         busy_o,
  input  axi_in_req_t  axi_req_i,
  output axi_in_resp_t axi_rsp_o,
  output reqrsp_req_t  reqrsp_req_o,
  input  reqrsp_rsp_t  reqrsp_rsp_i
`ifdef XDMA_AXI_WRITE_PERF_EN
  ,
  output logic [31:0]  beat_cnt_o,
  output logic [31:0]  burst_cnt_o
`endif
);

  localparam int unsigned MaxSize = $clog2(DataBytes);
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned UsageW  = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  axi_id_t    id_q, id_d;
  logic [2:0] size_q, size_d;
  logic [1:0] burst_q, burst_d;
  addr_t      addr_q, addr_d;

  // B FIFO
  axi_id_t           bq_id_q   [MaxOutstanding];
  logic [1:0]        bq_resp_q [MaxOutstanding];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [UsageW-1:0] usage_q;
  logic              push, pop;
  logic [1:0]        push_resp;

  logic  aw_credit;
  logic  aw_err;
  logic  beat;
  addr_t step, addr_next;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // INCR increments from the size-aligned address, so an unaligned start
  // address becomes aligned from the second beat onwards.
  always_comb begin
    step      = addr_t'(1) << size_q;
    addr_next = (addr_q & ~(step - addr_t'(1))) + step;
  end

  assign aw_credit = (usage_q < UsageW'(MaxOutstanding));
  assign aw_err    = (axi_req_i.aw.burst == BurstWrap)
                   | (axi_req_i.aw.atop != '0)
                   | (32'(axi_req_i.aw.size) > MaxSize);
  assign pop       = (usage_q != '0) & axi_req_i.b_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    size_d    = size_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    push      = 1'b0;
    push_resp = RespOkay;
    beat      = 1'b0;

    // An all-zero request carries amo = AMONone.
    axi_rsp_o            = '0;
    reqrsp_req_o         = '0;
    reqrsp_req_o.p_ready = 1'b1;

    case (state_q)
      IDLE: begin
        // rst_ni only gates the output here so that nothing is offered during
        // reset. The handshake below uses the ungated credit, because the
        // flops are held in reset anyway.
        axi_rsp_o.aw_ready = aw_credit & rst_ni;
        if (axi_req_i.aw_valid && aw_credit) begin
          id_d    = axi_req_i.aw.id;
          cnt_d   = axi_req_i.aw.len;
          size_d  = axi_req_i.aw.size;
          burst_d = axi_req_i.aw.burst;
          addr_d  = axi_req_i.aw.addr;
          state_d = aw_err ? DRAIN : BURST;
        end
      end

      BURST: begin
        reqrsp_req_o.q_valid = axi_req_i.w_valid;
        reqrsp_req_o.q.addr  = addr_q;
        reqrsp_req_o.q.write = 1'b1;
        reqrsp_req_o.q.data  = axi_req_i.w.data;
        reqrsp_req_o.q.strb  = axi_req_i.w.strb;
        reqrsp_req_o.q.size  = size_q;
        axi_rsp_o.w_ready    = reqrsp_rsp_i.q_ready;
        if (axi_req_i.w_valid && reqrsp_rsp_i.q_ready) begin
          beat   = 1'b1;
          cnt_d  = cnt_q - 8'd1;
          addr_d = (burst_q == BurstFixed) ? addr_q : addr_next;
          if (cnt_q == '0) begin
            push      = 1'b1;
            push_resp = RespOkay;
            state_d   = IDLE;
          end
        end
      end

      DRAIN: begin
        axi_rsp_o.w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          beat  = 1'b1;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == '0) begin
            push      = 1'b1;
            push_resp = RespSlvErr;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    axi_rsp_o.b_valid = (usage_q != '0);
    axi_rsp_o.b.id    = bq_id_q[rptr_q];
    axi_rsp_o.b.resp  = bq_resp_q[rptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        bq_id_q[i]   <= '0;
        bq_resp_q[i] <= '0;
      end
    end else begin
      if (push) begin
        bq_id_q[wptr_q]   <= id_q;
        bq_resp_q[wptr_q] <= push_resp;
        wptr_q            <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   usage_q <= usage_q + UsageW'(1);
        2'b01:   usage_q <= usage_q - UsageW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE) | (usage_q != '0)
                | axi_req_i.aw_valid | axi_req_i.w_valid;

`ifdef XDMA_AXI_WRITE_PERF_EN
  logic [31:0] beat_cnt_q, burst_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (beat) beat_cnt_q  <= beat_cnt_q + 32'd1;
      if (pop)  burst_cnt_q <= burst_cnt_q + 32'd1;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign burst_cnt_o = burst_cnt_q;
`endif

  // The whole input structs are listed so that fields left unused by this
  // write-only bridge (AR, r_ready, w.last, the p channel) are consumed.
  logic unused_inputs;
  assign unused_inputs = ^{axi_req_i, reqrsp_rsp_i, beat};

endmodule

// File: tb/tb_xdma_axi_to_reqrsp_write.sv
module tb_xdma_axi_to_reqrsp_write;
  import xdma_axi_to_reqrsp_write_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        busy;
  axi_req_t    req;
  axi_resp_t   rsp;
  reqrsp_req_t rq;
  reqrsp_rsp_t rs;
`ifdef XDMA_AXI_WRITE_PERF_EN
  logic [31:0] beat_cnt;
  logic [31:0] burst_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  xdma_axi_to_reqrsp_write #(.MaxOutstanding(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .busy_o       (busy),
    .axi_req_i    (req),
    .axi_rsp_o    (rsp),
    .reqrsp_req_o (rq),
    .reqrsp_rsp_i (rs)
`ifdef XDMA_AXI_WRITE_PERF_EN
    ,
    .beat_cnt_o   (beat_cnt),
    .burst_cnt_o  (burst_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [3:0] id);
    req.aw       = '0;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = burst;
    req.aw.id    = id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    rs    = '0;
    repeat (2) cyc();
    #1;
    n_assert++; if (rsp.aw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aw_ready: got %0b want 0", rsp.aw_ready); end
    n_assert++; if (rsp.w_ready !== 1'b0) begin n_fail++; $display("FAIL rst_w_ready: got %0b want 0", rsp.w_ready); end
    n_assert++; if (rsp.b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid: got %0b want 0", rsp.b_valid); end
    n_assert++; if (rq.q_valid !== 1'b0) begin n_fail++; $display("FAIL rst_q_valid: got %0b want 0", rq.q_valid); end
    n_assert++; if (rq.p_ready !== 1'b1) begin n_fail++; $display("FAIL rst_p_ready: got %0b want 1", rq.p_ready); end
    n_assert++; if (rq.q.amo !== AMONone) begin n_fail++; $display("FAIL rst_amo: got %0h want 0", rq.q.amo); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_assert++; if ({rsp.ar_ready, rsp.r_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_ar_r: got %b want 00", {rsp.ar_ready, rsp.r_valid}); end
    cyc();
    rst_n = 1'b1;
    #1;
    n_assert++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_aw_ready: got %0b want 1", rsp.aw_ready); end
  endtask

  task automatic test_incr();
    logic [31:0] exp_a [4] = '{32'h100, 32'h108, 32'h110, 32'h118};
    logic [63:0] exp_d [4] = '{64'hD000, 64'hD001, 64'hD002, 64'hD003};
    cyc();
    set_aw(32'h100, 8'd3, 2'b01, 4'd5);
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    req.w.data   = exp_d[0];
    req.w.strb   = 8'hFF;
    rs.q_ready   = 1'b1;
    #1;
    n_assert++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $display("FAIL incr_aw_ready: got %0b want 1", rsp.aw_ready); end
    n_assert++; if ({rsp.w_ready, rq.q_valid} !== 2'b00) begin n_fail++; $display("FAIL incr_no_w_in_aw_cycle: got %b want 00", {rsp.w_ready, rq.q_valid}); end
    cyc();
    req.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req.w.data = exp_d[i];
      #1;
      n_assert++; if (rq.q_valid !== 1'b1) begin n_fail++; $display("FAIL incr_q_valid[%0d]: got %0b want 1", i, rq.q_valid); end
      n_assert++; if (rq.q.addr !== exp_a[i]) begin n_fail++; $display("FAIL incr_addr[%0d]: got %h want %h", i, rq.q.addr, exp_a[i]); end
      n_assert++; if ({rq.q.write, rq.q.data, rq.q.strb, rq.q.size} !== {1'b1, exp_d[i], 8'hFF, 3'd3}) begin n_fail++; $display("FAIL incr_payload[%0d]: got %b/%h/%h/%0d want 1/%h/ff/3", i, rq.q.write, rq.q.data, rq.q.strb, rq.q.size, exp_d[i]); end
      n_assert++; if (rsp.b_valid !== 1'b0) begin n_fail++; $display("FAIL incr_early_b[%0d]: got %0b want 0", i, rsp.b_valid); end
      cyc();
    end
    req.w_valid = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.b.resp} !== {1'b1, 4'd5, 2'b00}) begin n_fail++; $display("FAIL incr_b: got v%0b id%0d r%0d want v1 id5 r0", rsp.b_valid, rsp.b.id, rsp.b.resp); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL incr_busy_b_pending: got %0b want 1", busy); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL incr_b_popped: got %b want 00", {rsp.b_valid, busy}); end
  endtask

  task automatic test_aligned();
    logic [31:0] exp_a [2] = '{32'h104, 32'h108};
    set_aw(32'h104, 8'd1, 2'b01, 4'd1);
    req.aw_valid = 1'b1;
    cyc();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    rs.q_ready   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_assert++; if (rq.q.addr !== exp_a[i]) begin n_fail++; $display("FAIL aligned_addr[%0d]: got %h want %h", i, rq.q.addr, exp_a[i]); end
      cyc();
    end
    req.w_valid = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.b.resp} !== {1'b1, 4'd1, 2'b00}) begin n_fail++; $display("FAIL aligned_b: got v%0b id%0d r%0d want v1 id1 r0", rsp.b_valid, rsp.b.id, rsp.b.resp); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
  endtask

  task automatic test_fixed();
    int acc = 0;
    set_aw(32'h40, 8'd2, 2'b00, 4'd3);
    req.aw_valid = 1'b1;
    cyc();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rs.q_ready = (k % 2 == 0);
      #1;
      n_assert++; if (rsp.w_ready !== rs.q_ready) begin n_fail++; $display("FAIL fixed_w_ready[%0d]: got %0b want %0b", k, rsp.w_ready, rs.q_ready); end
      n_assert++; if ({rq.q_valid, rq.q.addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL fixed_q[%0d]: got v%0b a%h want v1 a00000040", k, rq.q_valid, rq.q.addr); end
      if (rs.q_ready) acc++;
      cyc();
      if (acc == 3) break;
    end
    req.w_valid = 1'b0;
    rs.q_ready  = 1'b1;
    #1;
    n_assert++; if (acc !== 3) begin n_fail++; $display("FAIL fixed_beats: got %0d want 3", acc); end
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.b.resp} !== {1'b1, 4'd3, 2'b00}) begin n_fail++; $display("FAIL fixed_b: got v%0b id%0d r%0d want v1 id3 r0", rsp.b_valid, rsp.b.id, rsp.b.resp); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
  endtask

  task automatic test_wrap_drain();
    set_aw(32'h80, 8'd1, 2'b10, 4'd2);
    req.aw_valid = 1'b1;
    cyc();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    rs.q_ready   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_assert++; if ({rsp.w_ready, rq.q_valid} !== 2'b10) begin n_fail++; $display("FAIL drain_beat[%0d]: got w_ready,q_valid=%b want 10", i, {rsp.w_ready, rq.q_valid}); end
      cyc();
    end
    req.w_valid = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.b.resp} !== {1'b1, 4'd2, 2'b10}) begin n_fail++; $display("FAIL drain_b: got v%0b id%0d r%0d want v1 id2 r2", rsp.b_valid, rsp.b.id, rsp.b.resp); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
  endtask

  task automatic test_outstanding();
    logic [3:0] ids [2] = '{4'd6, 4'd7};
    req.b_ready = 1'b0;
    rs.q_ready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_aw(32'h200, 8'd0, 2'b01, ids[i]);
      req.aw_valid = 1'b1;
      #1;
      n_assert++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $display("FAIL outst_aw_ready[%0d]: got %0b want 1", i, rsp.aw_ready); end
      cyc();
      req.aw_valid = 1'b0;
      req.w_valid  = 1'b1;
      cyc();
      req.w_valid = 1'b0;
    end
    set_aw(32'h300, 8'd0, 2'b01, 4'd8);
    req.aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_assert++; if (rsp.aw_ready !== 1'b0) begin n_fail++; $display("FAIL outst_full_aw_ready[%0d]: got %0b want 0", i, rsp.aw_ready); end
      cyc();
    end
    req.b_ready = 1'b1;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id} !== {1'b1, 4'd6}) begin n_fail++; $display("FAIL outst_b0: got v%0b id%0d want v1 id6", rsp.b_valid, rsp.b.id); end
    cyc();
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.aw_ready} !== {1'b1, 4'd7, 1'b1}) begin n_fail++; $display("FAIL outst_b1: got v%0b id%0d aw_ready%0b want v1 id7 aw_ready1", rsp.b_valid, rsp.b.id, rsp.aw_ready); end
    cyc();
    req.aw_valid = 1'b0;
    req.b_ready  = 1'b0;
    req.w_valid  = 1'b1;
    #1;
    n_assert++; if ({rsp.b_valid, rq.q_valid, rq.q.addr} !== {1'b0, 1'b1, 32'h300}) begin n_fail++; $display("FAIL outst_third_aw: got b%0b q%0b a%h want b0 q1 a00000300", rsp.b_valid, rq.q_valid, rq.q.addr); end
    cyc();
    req.w_valid = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL outst_b2: got v%0b id%0d want v1 id8", rsp.b_valid, rsp.b.id); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    set_aw(32'h500, 8'd2, 2'b01, 4'd9);
    req.aw_valid = 1'b1;
    cyc();
    req.aw_valid = 1'b0;
    #1;
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_assert++; if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid, rq.q_valid, rq.p_ready, busy} !== 6'b000010) begin n_fail++; $display("FAIL midrst_outputs: got %b want 000010", {rsp.aw_ready, rsp.w_ready, rsp.b_valid, rq.q_valid, rq.p_ready, busy}); end
    cyc();
    rst_n = 1'b1;
`ifdef XDMA_AXI_WRITE_PERF_EN
    #1;
    n_assert++; if ({beat_cnt, burst_cnt} !== 64'd0) begin n_fail++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", beat_cnt, burst_cnt); end
`endif
    cyc();
    set_aw(32'h600, 8'd0, 2'b01, 4'd4);
    req.aw_valid = 1'b1;
    cyc();
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b1;
    rs.q_ready   = 1'b1;
    #1;
    n_assert++; if ({rq.q_valid, rq.q.addr} !== {1'b1, 32'h600}) begin n_fail++; $display("FAIL midrst_next_q: got v%0b a%h want v1 a00000600", rq.q_valid, rq.q.addr); end
    cyc();
    req.w_valid = 1'b0;
    #1;
    n_assert++; if ({rsp.b_valid, rsp.b.id, rsp.b.resp} !== {1'b1, 4'd4, 2'b00}) begin n_fail++; $display("FAIL midrst_b: got v%0b id%0d r%0d want v1 id4 r0", rsp.b_valid, rsp.b.id, rsp.b.resp); end
    req.b_ready = 1'b1;
    cyc();
    req.b_ready = 1'b0;
`ifdef XDMA_AXI_WRITE_PERF_EN
    #1;
    n_assert++; if ({beat_cnt, burst_cnt} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL midrst_perf_after: got %0d/%0d want 1/1", beat_cnt, burst_cnt); end
`endif
    #1;
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy %0b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_aligned();
    test_fixed();
    test_wrap_drain();
    test_outstanding();
    test_reset_mid_burst();
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
